// File: rtl/vga_pkg.sv
// vga_pkg: shared types and default 640x480@60 timing for the VGA sync generator.
package vga_pkg;

    // Width of the x/y counters; holds both 800 and 525 comfortably.
    localparam int CNT_W = 10;

    // Default 640x480@60 horizontal timing, in pixels.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Default 640x480@60 vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Phase of one scan axis, visited in declaration order and then back to ACTIVE.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one scan axis (counter plus ACTIVE/FRONT/SYNC/BACK phase FSM).
// The counter steps on adv; wrap flags the step that returns the counter to 0.
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FP_LEN     = DEF_H_FP,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BP_LEN     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    // Counts at which each phase after ACTIVE begins, and the last legal count.
    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE_LEN + FP_LEN);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    phase_t           phase_q;
    phase_t           phase_d;
    logic             at_end;

    // Anything at or beyond the last count folds back to 0, so a corrupted
    // counter resynchronises on the next advance.
    assign at_end = (cnt_q >= LAST);
    assign wrap   = adv & at_end;

    // Next count and next phase; a phase moves on when the new count reaches its boundary.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (adv) begin
            if (at_end) begin
                cnt_d   = '0;
                phase_d = ACTIVE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                case (phase_q)
                    ACTIVE:  if (cnt_d == FRONT_AT) phase_d = FRONT;
                    FRONT:   if (cnt_d == SYNC_AT)  phase_d = SYNC;
                    SYNC:    if (cnt_d == BACK_AT)  phase_d = BACK;
                    BACK:    phase_d = BACK;
                    default: phase_d = ACTIVE;
                endcase
            end
        end
    end

    // Counter and phase registers; reset restarts the axis at count 0 in ACTIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt   = cnt_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator built from a horizontal and a vertical axis timer.
// Optional macro VGA_SYNC_INTDIV_EN: derive the pixel strobe from an internal clk/2
// toggle flop and ignore the pix_en input.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    logic   strobe;
    logic   h_wrap;
    logic   v_wrap_unused;
    phase_t h_phase;
    phase_t v_phase;

`ifdef VGA_SYNC_INTDIV_EN
    logic div_q;
    logic pix_en_unused;

    assign pix_en_unused = pix_en;

    // Toggle flop: first strobe lands on the 2nd clk after reset release, then every 2nd clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign strobe = div_q;
`else
    assign strobe = pix_en;
`endif

    vga_axis_timer #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_timer (
        .clk   (clk),
        .rst   (rst),
        .adv   (strobe),
        .cnt   (x),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_timer #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_timer (
        .clk   (clk),
        .rst   (rst),
        .adv   (h_wrap),
        .cnt   (y),
        .phase (v_phase),
        .wrap  (v_wrap_unused)
    );

    // Outputs decode straight from the registered state; reset forces them idle
    // even before the first reset edge has cleared the counters.
    always_comb begin
        hsync       = ~SYNC_POL;
        vsync       = ~SYNC_POL;
        video_on    = 1'b0;
        line_start  = 1'b0;
        frame_start = 1'b0;
        if (!rst) begin
            if (h_phase == SYNC) hsync = SYNC_POL;
            if (v_phase == SYNC) vsync = SYNC_POL;
            video_on    = (h_phase == ACTIVE) && (v_phase == ACTIVE);
            line_start  = strobe && (x == '0);
            frame_start = strobe && (x == '0) && (y == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen (default build, pix_en driven by the bench).
// The vertical timing is shortened to 20/3/2/5 lines (30-line frame) so a full frame
// fits in a short run; horizontal timing keeps the 640x480@60 defaults.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;

    int total = 0;
    int bad   = 0;
    int ls_count;
    int fs_count;
    int vlow_count;

    vga_sync_gen #(
        .V_ACTIVE (20),
        .V_FP     (3),
        .V_SYNC   (2),
        .V_BP     (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // n pixel strobes, pix_en high on every 2nd clk; tallies pulses seen while pix_en is high.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_en = 1'b1;
            #1;
            if (line_start === 1'b1)  ls_count++;
            if (frame_start === 1'b1) fs_count++;
            if (vsync === 1'b0)       vlow_count++;
            @(negedge clk);
            pix_en = 1'b0;
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        pix_en     = 1'b0;
        ls_count   = 0;
        fs_count   = 0;
        vlow_count = 0;

        // Reset held: outputs idle, even with pix_en high.
        #1;
        checkOutput("rst_hsync", hsync, 1);
        checkOutput("rst_vsync", vsync, 1);
        checkOutput("rst_video_on", video_on, 0);
        repeat (2) @(negedge clk);
        pix_en = 1'b1;
        #1;
        checkOutput("rst_x", x, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_line_start", line_start, 0);
        checkOutput("rst_frame_start", frame_start, 0);

        @(negedge clk);
        rst    = 1'b0;
        pix_en = 1'b0;
        #1;
        checkOutput("rel_x", x, 0);
        checkOutput("rel_y", y, 0);
        checkOutput("rel_video_on", video_on, 1);
        checkOutput("rel_hsync", hsync, 1);
        checkOutput("rel_vsync", vsync, 1);

        // First strobe at (0,0) raises both start pulses.
        @(negedge clk);
        pix_en = 1'b1;
        #1;
        checkOutput("first_line_start", line_start, 1);
        checkOutput("first_frame_start", frame_start, 1);
        @(negedge clk);
        pix_en = 1'b0;
        #1;
        checkOutput("x_after_first", x, 1);
        checkOutput("line_start_no_strobe", line_start, 0);

        // Horizontal phase boundaries on line 0.
        applyStimulus(638);
        checkOutput("x639", x, 639);
        checkOutput("video_on_x639", video_on, 1);
        applyStimulus(1);
        checkOutput("video_on_x640", video_on, 0);
        checkOutput("hsync_x640", hsync, 1);
        applyStimulus(15);
        checkOutput("hsync_x655", hsync, 1);
        applyStimulus(1);
        checkOutput("hsync_x656", hsync, 0);
        applyStimulus(95);
        checkOutput("hsync_x751", hsync, 0);
        applyStimulus(1);
        checkOutput("hsync_x752", hsync, 1);
        applyStimulus(47);
        checkOutput("x799", x, 799);
        checkOutput("y_at_x799", y, 0);

        // Line wrap and one line_start per 800 strobes.
        applyStimulus(1);
        checkOutput("x_wrap", x, 0);
        checkOutput("y_step", y, 1);
        checkOutput("line_start_idle_x0", line_start, 0);
        ls_count = 0;
        applyStimulus(800);
        checkOutput("line_start_per_line", ls_count, 1);
        checkOutput("x_line2", x, 0);
        checkOutput("y_line2", y, 2);

        // Hold: pix_en low for 100 clk at x=300.
        applyStimulus(300);
        repeat (100) @(negedge clk);
        #1;
        checkOutput("hold_x", x, 300);
        checkOutput("hold_y", y, 2);
        checkOutput("hold_hsync", hsync, 1);
        checkOutput("hold_vsync", vsync, 1);
        checkOutput("hold_video_on", video_on, 1);

        // Rest of the frame: vsync only on lines 23..24, wrap 29 -> 0.
        ls_count   = 0;
        fs_count   = 0;
        vlow_count = 0;
        applyStimulus(16499);
        checkOutput("y22", y, 22);
        checkOutput("vsync_y22", vsync, 1);
        applyStimulus(1);
        checkOutput("y23", y, 23);
        checkOutput("vsync_y23", vsync, 0);
        checkOutput("video_on_y23_x0", video_on, 0);
        applyStimulus(1599);
        checkOutput("vsync_y24_x799", vsync, 0);
        applyStimulus(1);
        checkOutput("y25", y, 25);
        checkOutput("vsync_y25", vsync, 1);
        applyStimulus(3999);
        checkOutput("y29", y, 29);
        checkOutput("x799_y29", x, 799);
        applyStimulus(1);
        checkOutput("frame_wrap_x", x, 0);
        checkOutput("frame_wrap_y", y, 0);
        checkOutput("video_on_frame_wrap", video_on, 1);
        checkOutput("frame_start_before_wrap", fs_count, 0);
        applyStimulus(1);
        checkOutput("frame_start_once", fs_count, 1);
        checkOutput("line_start_count", ls_count, 28);
        checkOutput("vsync_low_strobes", vlow_count, 1600);

        // Mid-frame reset at (300,5) with pix_en high.
        applyStimulus(4299);
        checkOutput("pre_rst_x", x, 300);
        checkOutput("pre_rst_y", y, 5);
        @(negedge clk);
        rst    = 1'b1;
        pix_en = 1'b1;
        #1;
        checkOutput("mid_rst_hsync", hsync, 1);
        checkOutput("mid_rst_vsync", vsync, 1);
        checkOutput("mid_rst_video_on", video_on, 0);
        @(negedge clk);
        #1;
        checkOutput("mid_rst_x", x, 0);
        checkOutput("mid_rst_y", y, 0);
        checkOutput("mid_rst_line_start", line_start, 0);
        checkOutput("mid_rst_frame_start", frame_start, 0);
        rst    = 1'b0;
        pix_en = 1'b0;
        #1;
        checkOutput("post_rst_video_on", video_on, 1);
        applyStimulus(3);
        checkOutput("post_rst_x", x, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0: sync active level (0 = active-low).
REQ-010 SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-011 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-012 SHALL have port pix_en, input, 1 bit: one-clk pixel strobe, nominally every 2nd clk.
REQ-013 SHALL have port hsync, output, 1 bit: horizontal sync.
REQ-014 SHALL have port vsync, output, 1 bit: vertical sync.
REQ-015 SHALL have port video_on, output, 1 bit: current pixel is visible.
REQ-016 SHALL have port x, output, 10 bits: horizontal pixel count, range 0..H_TOTAL-1.
REQ-017 SHALL have port y, output, 10 bits: vertical line count, range 0..V_TOTAL-1.
REQ-018 SHALL have port line_start, output, 1 bit: one-clk pulse.
REQ-019 SHALL have port frame_start, output, 1 bit: one-clk pulse.

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-021 Each axis SHALL run a 4-state phase FSM with states ACTIVE, FRONT, SYNC and BACK, visited in that order, then back to ACTIVE.
REQ-022 Horizontal FSM and x SHALL advance only on clk edges with pix_en=1; with pix_en=0, all state SHALL hold.
REQ-023 x SHALL increment by 1 per pix_en; at x=H_TOTAL-1 it SHALL wrap to 0.
REQ-024 Vertical FSM and y SHALL advance only on a horizontal wrap; at y=V_TOTAL-1 with a horizontal wrap, y SHALL wrap to 0.
REQ-025 Phase boundaries, horizontal: ACTIVE for x<H_ACTIVE; FRONT to x<H_ACTIVE+H_FP; SYNC to x<H_ACTIVE+H_FP+H_SYNC; BACK for the rest. Vertical phases use the same rule on y.
REQ-026 hsync SHALL equal SYNC_POL while the horizontal FSM is in SYNC, else ~SYNC_POL; vsync SHALL follow the same rule for the vertical FSM.
REQ-027 video_on SHALL be 1 exactly when both FSMs are in ACTIVE.
REQ-028 Outputs SHALL decode combinationally from the registered state (0-clk latency from the counters).
REQ-029 line_start = pix_en & (x==0).
REQ-030 frame_start = pix_en & (x==0) & (y==0).
REQ-031 x and y SHALL never exceed TOTAL-1; any out-of-range value SHALL resynchronise to 0 on the next pix_en.

Reset
REQ-032 On a clk edge with rst=1: x=0, y=0, both FSMs = ACTIVE.
REQ-033 While rst=1: hsync=~SYNC_POL, vsync=~SYNC_POL, video_on=0, line_start=0, frame_start=0.
REQ-034 rst SHALL override pix_en; asserting rst mid-frame SHALL restart at (0,0) on the next edge.

Configuration
REQ-035 Macro VGA_SYNC_INTDIV_EN defined: an internal toggle flop SHALL generate the pixel strobe at clk/2 (high on the 2nd clk after rst release, then every 2nd clk), and pix_en SHALL be ignored.
REQ-036 Macro VGA_SYNC_INTDIV_EN not defined: the pixel strobe SHALL be the pix_en input.

Structure
REQ-037 Package vga_pkg SHALL hold the phase enum typedef (ACTIVE/FRONT/SYNC/BACK) and the default 640x480@60 timing constants.
REQ-038 Sub-module vga_axis_timer (counter plus phase FSM, parameterised by the 4 segment lengths, with inputs adv and outputs cnt, phase, wrap) SHALL be instantiated twice: once for horizontal, once for vertical (adv = h.wrap).

Verification
REQ-039 Reset release, pix_en every 2nd clk -> hsync low at x=656 through 751, high at x=752; video_on=0 from x=640.
REQ-040 Line end: x 799->0 with y 0->1; line_start pulses once per 800 strobes.
REQ-041 420000 strobes -> frame_start exactly once, at (0,0); vsync low for y=490..491 only; y 524->0.
REQ-042 pix_en held 0 for 100 clk at x=300 -> x, y, hsync, vsync and video_on unchanged.
REQ-043 rst pulsed at (300,200) -> next edge x=0, y=0; hsync=1, vsync=1 and video_on=0 during rst.
REQ-044 VGA_SYNC_INTDIV_EN defined, pix_en tied 0 -> x advances once every 2 clk; hsync period = 1600 clk.
